// File: rtl/encoder_8_to_3_seq_if.sv
// Request/index bus of the registered 8-to-3 request encoder.
// Handshake: an index transfers on a rising clk edge where out_valid & out_ready are both 1; while out_valid is 1 and out_ready is 0, out_lines is held stable.
interface encoder_8_to_3_seq_if;
  logic [7:0] in_lines;
  logic [2:0] out_lines;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic       drop_err;
  logic       dbg_state;

  // Encoder side.
  modport slave (
    input  in_lines,
    input  out_ready,
    output out_lines,
    output out_valid,
    output pending,
    output drop_err,
    output dbg_state
  );

  // Request source / consumer side.
  modport master (
    output in_lines,
    output out_ready,
    input  out_lines,
    input  out_valid,
    input  pending,
    input  drop_err,
    input  dbg_state
  );
endinterface

// File: rtl/encoder_8_to_3_seq.sv
// Sticky pending register feeding a priority pick, presented as a 3-bit index.
// One index per accept; the presented index is never preempted.
module encoder_8_to_3_seq #(
  parameter int PRIORITY_HIGH_FIRST = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  encoder_8_to_3_seq_if.slave         bus
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] out_lines_q, out_lines_d;
  logic       out_valid_q, out_valid_d;
  logic       drop_err_q, drop_err_d;

  logic       accept;
  logic [7:0] clear_mask;
  logic [7:0] avail;
  logic [2:0] winner;

  always_comb begin
    accept     = out_valid_q & bus.out_ready;
    clear_mask = 8'h00;
    if (accept) clear_mask = 8'b1 << out_lines_q;
    avail      = pending_q & ~clear_mask;
  end

  // Selection looks at registered pending only; this cycle's in_lines wait a clock.
  always_comb begin
    winner = 3'd0;
    if (PRIORITY_HIGH_FIRST != 0) begin
      for (int i = 0; i < 8; i++) begin
        if (avail[i]) winner = i[2:0];
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (avail[i]) winner = i[2:0];
      end
    end
  end

  always_comb begin
    pending_d   = avail | bus.in_lines;
    drop_err_d  = drop_err_q | (|(bus.in_lines & avail));
    state_d     = state_q;
    out_lines_d = out_lines_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (pending_q != 8'h00) begin
          out_lines_d = winner;
          out_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (accept) begin
          if (avail != 8'h00) begin
            out_lines_d = winner;
          end else begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= 8'h00;
      out_lines_q <= 3'd0;
      out_valid_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_lines_q <= out_lines_d;
      out_valid_q <= out_valid_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign bus.out_lines = out_lines_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pending   = pending_q;
  assign bus.drop_err  = drop_err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_encoder_8_to_3_seq.sv
// Bench for encoder_8_to_3_seq: a high-first and a low-first instance share stimulus
// and are compared each cycle against a behavioural model of pending/present/drop.
module tb_encoder_8_to_3_seq;

  logic clk;
  logic rst;

  encoder_8_to_3_seq_if if_hi ();
  encoder_8_to_3_seq_if if_lo ();

  encoder_8_to_3_seq #(.PRIORITY_HIGH_FIRST(1)) u_hi (
    .clk (clk),
    .rst (rst),
    .bus (if_hi.slave)
  );

  encoder_8_to_3_seq #(.PRIORITY_HIGH_FIRST(0)) u_lo (
    .clk (clk),
    .rst (rst),
    .bus (if_lo.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model, index 0 = lowest-first, 1 = highest-first.
  logic [7:0] m_pend [2];
  logic [2:0] m_idx  [2];
  logic       m_v    [2];
  logic       m_derr [2];

  function automatic logic [2:0] pick(input logic [7:0] set, input int hi);
    int k;
    if (hi != 0) begin
      for (k = 7; k >= 0; k--) if (set[k]) return 3'(k);
    end else begin
      for (k = 0; k < 8; k++) if (set[k]) return 3'(k);
    end
    return 3'd0;
  endfunction

  task automatic model_step(input logic [7:0] in_l, input logic rdy, input logic r);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        m_pend[d] = 8'h00; m_idx[d] = 3'd0; m_v[d] = 1'b0; m_derr[d] = 1'b0;
      end else begin
        logic       acc;
        logic [7:0] left;
        acc  = m_v[d] && rdy;
        left = m_pend[d];
        if (acc) left[m_idx[d]] = 1'b0;
        if ((in_l & left) != 8'h00) m_derr[d] = 1'b1;
        if (!m_v[d]) begin
          if (m_pend[d] != 8'h00) begin
            m_idx[d] = pick(m_pend[d], d);
            m_v[d]   = 1'b1;
          end
        end else if (acc) begin
          if (left != 8'h00) m_idx[d] = pick(left, d);
          else               m_v[d]   = 1'b0;
        end
        m_pend[d] = left | in_l;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Driver: apply inputs, clock once, advance model, compare both instances.
  task automatic cycle(input logic [7:0] in_l, input logic rdy, input logic r);
    if_hi.in_lines = in_l; if_lo.in_lines = in_l;
    if_hi.out_ready = rdy; if_lo.out_ready = rdy;
    rst = r;
    @(posedge clk);
    model_step(in_l, rdy, r);
    #1;
    chk("hi_out_lines", {5'd0, if_hi.out_lines}, {5'd0, m_idx[1]});
    chk("hi_out_valid", {7'd0, if_hi.out_valid}, {7'd0, m_v[1]});
    chk("hi_pending",   if_hi.pending,           m_pend[1]);
    chk("hi_drop_err",  {7'd0, if_hi.drop_err},  {7'd0, m_derr[1]});
    chk("lo_out_lines", {5'd0, if_lo.out_lines}, {5'd0, m_idx[0]});
    chk("lo_out_valid", {7'd0, if_lo.out_valid}, {7'd0, m_v[0]});
    chk("lo_pending",   if_lo.pending,           m_pend[0]);
    chk("lo_drop_err",  {7'd0, if_lo.drop_err},  {7'd0, m_derr[0]});
  endtask

  // Scoreboard of indices the high-first instance is expected to hand over.
  logic [7:0] exp_q[$];

  task automatic accept_expect(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, {7'd0, if_hi.out_valid}, 8'd1);
      chk({tag, "_index"}, {5'd0, if_hi.out_lines}, e);
    end
  endtask

  initial begin
    m_pend = '{8'h00, 8'h00}; m_idx = '{3'd0, 3'd0};
    m_v = '{1'b0, 1'b0};      m_derr = '{1'b0, 1'b0};
    if_hi.in_lines = 8'h00; if_lo.in_lines = 8'h00;
    if_hi.out_ready = 1'b0; if_lo.out_ready = 1'b0;
    rst = 1'b1;

    // Reset state
    cycle(8'h00, 1'b0, 1'b1);
    cycle(8'h00, 1'b0, 1'b1);
    chk("reset_valid",   {7'd0, if_hi.out_valid}, 8'd0);
    chk("reset_pending", if_hi.pending, 8'h00);

    // Single request, two-cycle latency
    cycle(8'h04, 1'b1, 1'b0);
    chk("t1_pending_set", if_hi.pending, 8'h04);
    chk("t1_not_yet_valid", {7'd0, if_hi.out_valid}, 8'd0);
    cycle(8'h00, 1'b1, 1'b0);
    chk("t1_valid", {7'd0, if_hi.out_valid}, 8'd1);
    chk("t1_index", {5'd0, if_hi.out_lines}, 8'd2);
    cycle(8'h00, 1'b1, 1'b0);
    chk("t1_idle_valid", {7'd0, if_hi.out_valid}, 8'd0);
    chk("t1_idle_pending", if_hi.pending, 8'h00);

    // Priority order over 8'hA1
    cycle(8'hA1, 1'b1, 1'b0);
    exp_q = '{8'd7, 8'd5, 8'd0};
    cycle(8'h00, 1'b1, 1'b0);
    chk("t2_lo_first", {5'd0, if_lo.out_lines}, 8'd0);
    accept_expect("t2_a");
    cycle(8'h00, 1'b1, 1'b0);
    chk("t2_lo_second", {5'd0, if_lo.out_lines}, 8'd5);
    accept_expect("t2_b");
    cycle(8'h00, 1'b1, 1'b0);
    chk("t2_lo_third", {5'd0, if_lo.out_lines}, 8'd7);
    accept_expect("t2_c");
    cycle(8'h00, 1'b1, 1'b0);
    chk("t2_idle", {7'd0, if_hi.out_valid}, 8'd0);

    // Backpressure and no preemption
    cycle(8'h12, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    chk("t3_held_4", {5'd0, if_hi.out_lines}, 8'd4);
    cycle(8'h80, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    chk("t3_no_preempt", {5'd0, if_hi.out_lines}, 8'd4);
    exp_q = '{8'd7, 8'd1};
    cycle(8'h00, 1'b1, 1'b0);
    accept_expect("t3_a");
    cycle(8'h00, 1'b1, 1'b0);
    accept_expect("t3_b");
    cycle(8'h00, 1'b1, 1'b0);
    chk("t3_idle", {7'd0, if_hi.out_valid}, 8'd0);

    // Re-request in own accept cycle: stays pending, re-presented, no drop error
    cycle(8'h08, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    chk("t4_presented", {5'd0, if_hi.out_lines}, 8'd3);
    cycle(8'h08, 1'b1, 1'b0);
    chk("t4_still_pending", if_hi.pending, 8'h08);
    chk("t4_no_drop", {7'd0, if_hi.drop_err}, 8'd0);
    cycle(8'h00, 1'b0, 1'b0);
    chk("t4_again_valid", {7'd0, if_hi.out_valid}, 8'd1);
    chk("t4_again_index", {5'd0, if_hi.out_lines}, 8'd3);
    cycle(8'h00, 1'b1, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);

    // Duplicate request sets sticky drop_err
    cycle(8'h40, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h40, 1'b0, 1'b0);
    chk("t5_drop_set", {7'd0, if_hi.drop_err}, 8'd1);
    for (int i = 0; i < 6; i++) cycle(8'h05, 1'b1, 1'b0);
    chk("t5_drop_sticky", {7'd0, if_hi.drop_err}, 8'd1);

    // Reset mid-operation
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'hF0, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    chk("t6_pre_valid", {7'd0, if_hi.out_valid}, 8'd1);
    cycle(8'hFF, 1'b1, 1'b1);
    chk("t6_valid", {7'd0, if_hi.out_valid}, 8'd0);
    chk("t6_index", {5'd0, if_hi.out_lines}, 8'd0);
    chk("t6_pending", if_hi.pending, 8'h00);
    chk("t6_drop", {7'd0, if_hi.drop_err}, 8'd0);

    // All eight pending, ready high: eight accepts then idle
    cycle(8'hFF, 1'b1, 1'b0);
    exp_q = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    for (int i = 0; i < 8; i++) begin
      cycle(8'h00, 1'b1, 1'b0);
      accept_expect("all8");
    end
    cycle(8'h00, 1'b1, 1'b0);
    chk("all8_idle", {7'd0, if_hi.out_valid}, 8'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [7:0] in_l;
      logic       rdy, r;
      in_l = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      rdy  = ($urandom_range(0, 2) != 0);
      r    = ($urandom_range(0, 79) == 0);
      cycle(in_l, rdy, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
